// File: rtl/alaw_pkg.sv
// Shared constants and FSM encoding for the linear-to-A-law encoder.
package alaw_pkg;
  localparam int MAG_W   = 12;
  localparam int SEG_W   = 3;
  localparam int QUANT_W = 4;
  localparam int LIN_W   = 13;
  localparam int ALAW_W  = 8;

  localparam logic [ALAW_W-1:0] EVEN_BIT_MASK = 8'h55;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    OUT
  } state_t;
endpackage

// File: rtl/alaw_quant_select.sv
// Picks the 4 mantissa bits that follow the implied leading one of a segment.
module alaw_quant_select
  import alaw_pkg::*;
(
  input  logic [MAG_W-1:0]   mag,
  input  logic [SEG_W-1:0]   seg,
  output logic [QUANT_W-1:0] quant
);

  // Segment 0 has no implied leading one, so it shares segment 1's bit window.
  always_comb begin
    if (seg == '0) quant = mag[4:1];
    else           quant = QUANT_W'(mag >> seg);
  end

endmodule

// File: rtl/alaw_encoder.sv
// Streaming linear-to-A-law encoder; segment search walks down one segment per clock.
// Optional macro ALAW_EVEN_BIT_INVERT_EN applies G.711 even-bit inversion at the output.
module alaw_encoder
  import alaw_pkg::*;
#(
  parameter logic [SEG_W-1:0] SEG_TOP = 3'd7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LIN_W-1:0]  in_lin,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ALAW_W-1:0] out_alaw
);

`ifdef ALAW_EVEN_BIT_INVERT_EN
  localparam logic [ALAW_W-1:0] OUT_MASK = EVEN_BIT_MASK;
`else
  localparam logic [ALAW_W-1:0] OUT_MASK = '0;
`endif

  state_t             state;
  state_t             state_nxt;
  logic [SEG_W-1:0]   seg;
  logic [MAG_W-1:0]   mag;
  logic               sign;
  logic [QUANT_W-1:0] quant;
  logic               hit;

  alaw_quant_select u_quant (
    .mag   (mag),
    .seg   (seg),
    .quant (quant)
  );

  // A segment matches when its leading-one position (seg+4) is set; segment 0 catches the rest.
  always_comb begin
    hit = (seg == '0) || (((mag >> seg) & MAG_W'(16)) != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = SCAN;
      end
      SCAN: begin
        if (hit) state_nxt = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign     <= 1'b0;
      mag      <= '0;
      seg      <= SEG_TOP;
      out_alaw <= OUT_MASK;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign <= in_lin[LIN_W-1];
            mag  <= in_lin[MAG_W-1:0];
            seg  <= SEG_TOP;
          end
        end
        SCAN: begin
          if (hit) out_alaw <= {sign, seg, quant} ^ OUT_MASK;
          else     seg      <= seg - SEG_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alaw_encoder.sv
// Directed bench for alaw_encoder: latency, codes, backpressure, reset abort and round trip.
module tb_alaw_encoder;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [12:0] in_lin;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_alaw;

  int checks = 0;
  int errors = 0;

`ifdef ALAW_EVEN_BIT_INVERT_EN
  localparam logic [7:0] MASK = 8'h55;
`else
  localparam logic [7:0] MASK = 8'h00;
`endif

  always #5 clk = ~clk;

  alaw_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_lin    (in_lin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_alaw  (out_alaw)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Offers one sample, then counts clocks until out_valid (bounded at 20).
  task automatic send(input logic [12:0] lin, output int lat, output logic ok);
    @(negedge clk);
    check("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_lin   = lin;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_lin   = ~lin;
    lat = 0;
    ok  = 1'b0;
    while (!ok && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (out_valid) ok = 1'b1;
    end
  endtask

  task automatic run(input string tag, input logic [12:0] lin, input logic [7:0] raw, input int exp_lat);
    int   lat;
    logic ok;
    send(lin, lat, ok);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_code"}, 32'(out_alaw), 32'(raw ^ MASK));
    check({tag, "_busy"}, 32'(in_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_idle"}, 32'({in_ready, out_valid}), 32'b10);
  endtask

  function automatic int decode(input logic [7:0] c);
    logic [7:0] r;
    int s;
    int q;
    r = c ^ MASK;
    s = int'(r[6:4]);
    q = int'(r[3:0]);
    if (s == 0) return 2 * q + 1;
    return ((16 + q) << s) + (1 << (s - 1));
  endfunction

  initial begin
    int   lat;
    logic ok;
    int   seen;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_lin    = '0;
    out_ready = 1'b1;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_alaw", 32'(out_alaw), 32'(MASK));
    @(negedge clk);
    rst = 1'b0;

    run("zero",      13'h0000, 8'h00, 8);
    run("neg_zero",  13'h1000, 8'h80, 8);
    run("max_neg",   13'h1FFF, 8'hFF, 1);
    run("max_pos",   13'h0FFF, 8'h7F, 1);
    run("mag33",     13'h0021, 8'h10, 7);
    run("mag100",    13'h0064, 8'h29, 6);
    run("mag2048",   13'h0800, 8'h70, 1);
    run("mag31",     13'h001F, 8'h0F, 8);
    run("neg16",     13'h1010, 8'h88, 8);
    run("mag32",     13'h0020, 8'h10, 7);
    run("mag63",     13'h003F, 8'h1F, 7);
    run("mag1365",   13'h0555, 8'h65, 2);

    // Backpressure: code must hold while out_ready is low.
    out_ready = 1'b0;
    send(13'h0064, lat, ok);
    check("bp_lat", 32'(lat), 32'd6);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_hold", 32'({out_valid, in_ready, out_alaw}), 32'({2'b10, 8'h29 ^ MASK}));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("bp_release", 32'({in_ready, out_valid}), 32'b10);
    out_ready = 1'b1;

    // Reset mid-SCAN aborts the transaction.
    @(negedge clk);
    in_valid = 1'b1;
    in_lin   = 13'h0000;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("abort_no_out", 32'(seen), 32'd0);
    run("after_rst", 13'h0FFF, 8'h7F, 1);

    // Round trip through a reference expander over a stride of all inputs.
    for (int i = 0; i < 8192; i += 3) begin
      logic [12:0] lin;
      int          dec;
      int          err;
      int          s;
      int          tol;
      lin = 13'(i);
      send(lin, lat, ok);
      if (!ok) begin
        check("rt_timeout", 32'd0, 32'd1);
      end else begin
        dec = decode(out_alaw);
        s   = int'(((out_alaw ^ MASK) >> 4) & 8'h07);
        err = dec - int'(lin[11:0]);
        if (err < 0) err = -err;
        tol = (s <= 1) ? 2 : (1 << s);
        check("rt_mag", 32'(err <= tol), 32'd1);
        check("rt_sign", 32'((out_alaw ^ MASK) >> 7), 32'(lin[12]));
      end
      @(posedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
